uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Byte-command controller between the UART receive/transmit pair and an internal register file.
- Parses frames from the receiver and executes register writes and reads.
- Sequences the transmitter to return read data.
- Register 0 drives the UART framing configuration (parity enable, parity type, prescale), so the block both sequences and configures the UART datapath.

Parameters:
- WIDTH, 8, data byte width (fixed at 8 for the command encoding).
- PRESCALE_WIDTH, 5, width of the prescale configuration output.
- ADDR_WIDTH, 3, register file address bits; DEPTH = 2^ADDR_WIDTH registers.

Ports:
- CLK  input  1  single system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_P_DATA  input  WIDTH  received byte.
- RX_DATA_VALID  input  1  one-cycle strobe; RX_P_DATA is valid.
- RX_PAR_ERR  input  1  parity error, qualified by RX_DATA_VALID.
- RX_STP_ERR  input  1  stop error, qualified by RX_DATA_VALID.
- TX_P_DATA  output  WIDTH  byte to transmit.
- TX_DATA_VALID  output  1  one-cycle transmit request.
- TX_BUSY  input  1  transmitter busy, synchronous to CLK.
- CFG_PAR_EN  output  1  REG0[0].
- CFG_PAR_TYP  output  1  REG0[1].
- CFG_PRESCALE  output  PRESCALE_WIDTH  REG0[6:2].
- CMD_ERR  output  1  one-cycle error pulse.
- ERR_CNT  output  8  saturating error counter.
- CTRL_BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - TX_P_DATA=0x00, TX_DATA_VALID=0, CMD_ERR=0, ERR_CNT=0, CTRL_BUSY=0.
  - REG0=0x21 (PAR_EN=1, PAR_TYP=0, PRESCALE=8); REG1..DEPTH-1=0x00.
  - A reset asserted mid-command or mid-transmit aborts and restores all of the above on the next edge.
- Commands (first byte): 0xAA = write (addr, data); 0xBB = read (addr). Any other first byte: CMD_ERR pulse, stay IDLE.
- States and transitions:
  - IDLE: on good byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR.
  - WR_ADDR: on good byte, latch addr -> WR_DATA.
  - WR_DATA: on good byte, write REG[addr] in the same edge -> IDLE.
  - RD_ADDR: on good byte, latch addr -> TX_REQ.
  - TX_REQ: when TX_BUSY=0, drive TX_P_DATA=REG[addr] and pulse TX_DATA_VALID for exactly 1 cycle -> TX_START.
  - TX_START: wait for TX_BUSY=1 -> TX_WAIT.
  - TX_WAIT: wait for TX_BUSY=0 -> IDLE.
- TX_P_DATA holds its value from the TX_DATA_VALID cycle until the next request.
- Latency:
  - Write data is visible on the CFG outputs on the cycle after the edge that accepts the data byte.
  - TX_DATA_VALID asserts 1 cycle after the addr byte is accepted, provided TX_BUSY=0.
- Good byte: RX_DATA_VALID=1 with RX_PAR_ERR=0 and RX_STP_ERR=0.
- Bad byte (valid with either error) in any state: CMD_ERR pulse, partial command discarded, -> IDLE (an in-progress TX request in TX_* states is not aborted; see below).
- Address range: only the low ADDR_WIDTH bits index the file. If any upper bit is set:
  - Write: dropped, CMD_ERR pulse.
  - Read: returns 0x00, CMD_ERR pulse.
- RX_DATA_VALID during TX_REQ/TX_START/TX_WAIT: byte dropped, CMD_ERR pulse, state unchanged.
- ERR_CNT increments by 1 on every CMD_ERR pulse and saturates at 0xFF (no wrap). A write of any data to address 0x7F clears ERR_CNT; this is the one out-of-range write that does not pulse CMD_ERR.
- Simultaneous CMD_ERR and counter clear: clear wins.
- Register file: writes only from WR_DATA; REG0 bit 7 is stored and reads back, no effect.
- No timeout on partial commands: the controller waits indefinitely for the next byte.

Test Plan:
- Reset, then read REG0 (0xBB, 0x00) -> TX_DATA_VALID 1-cycle pulse with TX_P_DATA=0x21; state returns IDLE after TX_BUSY falls.
- Write 0xAA,0x00,0x42 -> CFG_PAR_EN=0, CFG_PAR_TYP=1, CFG_PRESCALE=16 on the next cycle; read REG0 returns 0x42.
- Write 0xAA,0x03,0x5C, then read 0xBB,0x03 while TX_BUSY held high 10 cycles -> TX_DATA_VALID delayed until TX_BUSY=0, data 0x5C, single pulse.
- 0xAA followed by a byte with RX_PAR_ERR=1 -> CMD_ERR pulse, ERR_CNT=1, IDLE; next 0xAA,0x01,0x11 writes REG1=0x11 normally.
- Unknown byte 0x55 sent 300 times -> ERR_CNT saturates at 0xFF; write 0xAA,0x7F,0x00 -> ERR_CNT=0x00, no CMD_ERR pulse.
- Read 0xBB,0x09 (out of range) -> TX_P_DATA=0x00, CMD_ERR pulse; assert RST during TX_WAIT -> all outputs at reset values, REG0=0x21.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - byte-command controller bridging UART rx/tx to a small register file
// Register 0 also drives the UART framing configuration (parity enable/type, prescale).
module uart_cmd_ctrl #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 5,
    parameter int ADDR_WIDTH     = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          RX_P_DATA,
    input  logic                      RX_DATA_VALID,
    input  logic                      RX_PAR_ERR,
    input  logic                      RX_STP_ERR,
    output logic [WIDTH-1:0]          TX_P_DATA,
    output logic                      TX_DATA_VALID,
    input  logic                      TX_BUSY,
    output logic                      CFG_PAR_EN,
    output logic                      CFG_PAR_TYP,
    output logic [PRESCALE_WIDTH-1:0] CFG_PRESCALE,
    output logic                      CMD_ERR,
    output logic [7:0]                ERR_CNT,
    output logic                      CTRL_BUSY
);

    localparam int               DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [WIDTH-1:0] CMD_WR   = 8'hAA;
    localparam logic [WIDTH-1:0] CMD_RD   = 8'hBB;
    localparam logic [WIDTH-1:0] CLR_ADDR = 8'h7F;
    localparam logic [WIDTH-1:0] REG0_RST = 8'h21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_TX_REQ,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_valid;
    logic             r_cmd_err;
    logic [7:0]       r_err_cnt;

    logic             w_good;
    logic             w_bad;
    logic             w_addr_oor;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_err;
    logic             w_wr_en;
    logic             w_clr;
    logic             w_addr_ld;
    logic             w_tx_fire;

    assign w_good     = RX_DATA_VALID & ~RX_PAR_ERR & ~RX_STP_ERR;
    assign w_bad      = RX_DATA_VALID & (RX_PAR_ERR | RX_STP_ERR);
    assign w_addr_oor = |r_addr[WIDTH-1:ADDR_WIDTH];
    assign w_rd_data  = w_addr_oor ? '0 : r_regs[r_addr[ADDR_WIDTH-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_wr_en   = 1'b0;
        w_clr     = 1'b0;
        w_addr_ld = 1'b0;
        w_tx_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_good && RX_P_DATA == CMD_WR) begin
                    w_next = S_WR_ADDR;
                end else if (w_good && RX_P_DATA == CMD_RD) begin
                    w_next = S_RD_ADDR;
                end else if (RX_DATA_VALID) begin
                    w_err = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (w_good) begin
                    w_addr_ld = 1'b1;
                    w_next    = S_WR_DATA;
                end else if (w_bad) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (w_good) begin
                    w_next = S_IDLE;
                    // 0x7F is the counter-clear address, the only silent out-of-range write
                    if (!w_addr_oor) begin
                        w_wr_en = 1'b1;
                    end else if (r_addr == CLR_ADDR) begin
                        w_clr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_bad) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (w_good) begin
                    w_addr_ld = 1'b1;
                    w_err     = |RX_P_DATA[WIDTH-1:ADDR_WIDTH];
                    w_next    = S_TX_REQ;
                end else if (w_bad) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_TX_REQ: begin
                w_err = RX_DATA_VALID;
                if (!TX_BUSY) begin
                    w_tx_fire = 1'b1;
                    w_next    = S_TX_START;
                end
            end
            S_TX_START: begin
                w_err = RX_DATA_VALID;
                if (TX_BUSY) begin
                    w_next = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                w_err = RX_DATA_VALID;
                if (!TX_BUSY) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_err_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= (i == 0) ? REG0_RST : '0;
            end
        end else begin
            r_tx_valid <= w_tx_fire;
            r_cmd_err  <= w_err;
            if (w_addr_ld) begin
                r_addr <= RX_P_DATA;
            end
            if (w_wr_en) begin
                r_regs[r_addr[ADDR_WIDTH-1:0]] <= RX_P_DATA;
            end
            if (w_tx_fire) begin
                r_tx_data <= w_rd_data;
            end
            if (w_clr) begin
                r_err_cnt <= '0;
            end else if (w_err && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign TX_P_DATA     = r_tx_data;
    assign TX_DATA_VALID = r_tx_valid;
    assign CMD_ERR       = r_cmd_err;
    assign ERR_CNT       = r_err_cnt;
    assign CTRL_BUSY     = (r_state != S_IDLE);
    assign CFG_PAR_EN    = r_regs[0][0];
    assign CFG_PAR_TYP   = r_regs[0][1];
    assign CFG_PRESCALE  = r_regs[0][2 +: PRESCALE_WIDTH];

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
// Table-driven write/read vectors plus hand sequences; read data checked through a scoreboard queue.
module tb_uart_cmd_ctrl;

    logic       CLK           = 1'b0;
    logic       RST           = 1'b1;
    logic [7:0] RX_P_DATA     = 8'h00;
    logic       RX_DATA_VALID = 1'b0;
    logic       RX_PAR_ERR    = 1'b0;
    logic       RX_STP_ERR    = 1'b0;
    logic       TX_BUSY       = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_DATA_VALID;
    logic       CFG_PAR_EN;
    logic       CFG_PAR_TYP;
    logic [4:0] CFG_PRESCALE;
    logic       CMD_ERR;
    logic [7:0] ERR_CNT;
    logic       CTRL_BUSY;

    uart_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_DATA_VALID (RX_DATA_VALID),
        .RX_PAR_ERR    (RX_PAR_ERR),
        .RX_STP_ERR    (RX_STP_ERR),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (TX_BUSY),
        .CFG_PAR_EN    (CFG_PAR_EN),
        .CFG_PAR_TYP   (CFG_PAR_TYP),
        .CFG_PRESCALE  (CFG_PRESCALE),
        .CMD_ERR       (CMD_ERR),
        .ERR_CNT       (ERR_CNT),
        .CTRL_BUSY     (CTRL_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd;
        int         errs;
    } vec_t;

    vec_t       vecs [6];
    int         checks    = 0;
    int         failures  = 0;
    int         tx_seen   = 0;
    int         err_seen  = 0;
    int         err_exp   = 0;
    int         cnt_exp   = 0;
    logic [7:0] tx_exp [$];
    logic       tx_prev   = 1'b0;
    bit         force_busy = 1'b0;
    int         busy_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 4 cycles after each request, or held by force_busy
    always @(posedge CLK) begin
        #1;
        if (RST) busy_cnt = 0;
        else if (TX_DATA_VALID) busy_cnt = 4;
        else if (busy_cnt > 0) busy_cnt--;
        TX_BUSY = force_busy || (busy_cnt != 0);
    end

    always @(negedge CLK) begin
        if (TX_DATA_VALID) begin
            tx_seen++;
            check("tx_pulse_single", {31'd0, tx_prev}, 32'd0);
            if (tx_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got data 0x%0h with no request outstanding", TX_P_DATA);
            end else begin
                check("tx_data", {24'd0, TX_P_DATA}, {24'd0, tx_exp.pop_front()});
            end
        end
        if (CMD_ERR) err_seen++;
        tx_prev = TX_DATA_VALID;
    end

    task automatic send(input logic [7:0] d, input logic par, input logic stp);
        @(posedge CLK); #1;
        RX_P_DATA     = d;
        RX_DATA_VALID = 1'b1;
        RX_PAR_ERR    = par;
        RX_STP_ERR    = stp;
        @(posedge CLK); #1;
        RX_DATA_VALID = 1'b0;
        RX_PAR_ERR    = 1'b0;
        RX_STP_ERR    = 1'b0;
    endtask

    task automatic expect_err();
        err_exp++;
        if (cnt_exp < 255) cnt_exp++;
    endtask

    task automatic check_errs(input string name);
        @(negedge CLK); #1;
        check({name, "_err_pulses"}, err_seen, err_exp);
        check({name, "_err_cnt"}, {24'd0, ERR_CNT}, cnt_exp);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge CLK); #1;
        while (CTRL_BUSY && n < 200) begin
            @(negedge CLK); #1;
            n++;
        end
        check({name, "_idle"}, {31'd0, CTRL_BUSY}, 32'd0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        send(8'hAA, 1'b0, 1'b0);
        send(addr, 1'b0, 1'b0);
        send(data, 1'b0, 1'b0);
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
        int s = tx_seen;
        send(8'hBB, 1'b0, 1'b0);
        tx_exp.push_back(exp);
        send(addr, 1'b0, 1'b0);
        @(negedge CLK); #1;
        check({name, "_tx_not_early"}, {31'd0, TX_DATA_VALID}, 32'd0);
        @(negedge CLK); #1;
        check({name, "_tx_latency"}, {31'd0, TX_DATA_VALID}, 32'd1);
        wait_idle(name);
        check({name, "_tx_count"}, tx_seen - s, 32'd1);
        check({name, "_tx_hold"}, {24'd0, TX_P_DATA}, {24'd0, exp});
    endtask

    initial begin
        int s;
        int n;
        vecs[0] = '{8'h00, 8'h42, 8'h42, 0};
        vecs[1] = '{8'h03, 8'h5C, 8'h5C, 0};
        vecs[2] = '{8'h07, 8'hFF, 8'hFF, 0};
        vecs[3] = '{8'h02, 8'h3C, 8'h3C, 0};
        vecs[4] = '{8'h09, 8'h77, 8'h00, 2};
        vecs[5] = '{8'h00, 8'hA5, 8'hA5, 0};

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK); #1;
        check("rst_tx_data", {24'd0, TX_P_DATA}, 32'h00);
        check("rst_tx_valid", {31'd0, TX_DATA_VALID}, 32'd0);
        check("rst_cmd_err", {31'd0, CMD_ERR}, 32'd0);
        check("rst_err_cnt", {24'd0, ERR_CNT}, 32'd0);
        check("rst_busy", {31'd0, CTRL_BUSY}, 32'd0);
        check("rst_par_en", {31'd0, CFG_PAR_EN}, 32'd1);
        check("rst_par_typ", {31'd0, CFG_PAR_TYP}, 32'd0);
        check("rst_prescale", {27'd0, CFG_PRESCALE}, 32'd8);
        do_read("rd_reg0_rst", 8'h00, 8'h21);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].data);
            if (vecs[i].addr == 8'h00) begin
                check($sformatf("vec%0d_par_en", i), {31'd0, CFG_PAR_EN}, {31'd0, vecs[i].data[0]});
                check($sformatf("vec%0d_par_typ", i), {31'd0, CFG_PAR_TYP}, {31'd0, vecs[i].data[1]});
                check($sformatf("vec%0d_prescale", i), {27'd0, CFG_PRESCALE}, {27'd0, vecs[i].data[6:2]});
            end
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd);
            for (int k = 0; k < vecs[i].errs; k++) expect_err();
            check_errs($sformatf("vec%0d", i));
        end

        // Read held off by a busy transmitter; a byte arriving meanwhile is dropped
        force_busy = 1'b1;
        repeat (2) @(posedge CLK);
        s = tx_seen;
        send(8'hBB, 1'b0, 1'b0);
        tx_exp.push_back(8'h5C);
        send(8'h03, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK); #1;
            check("busy_hold_no_tx", {31'd0, TX_DATA_VALID}, 32'd0);
            if (k == 4) begin
                send(8'hAA, 1'b0, 1'b0);
                expect_err();
            end
        end
        check_errs("busy_drop");
        force_busy = 1'b0;
        wait_idle("busy_hold");
        check("busy_hold_tx_count", tx_seen - s, 32'd1);

        // Framing errors abort a partial command
        do_read("rd_reg1_noalias", 8'h01, 8'h00);
        send(8'hAA, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        expect_err();
        check_errs("par_err");
        check("par_err_idle", {31'd0, CTRL_BUSY}, 32'd0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b1);
        expect_err();
        check_errs("stp_err");
        check("stp_err_idle", {31'd0, CTRL_BUSY}, 32'd0);
        do_write(8'h01, 8'h11);
        do_read("rd_reg1_after_err", 8'h01, 8'h11);

        for (int k = 0; k < 300; k++) begin
            send(8'h55, 1'b0, 1'b0);
            expect_err();
        end
        check_errs("saturate");
        do_write(8'h7F, 8'h00);
        cnt_exp = 0;
        check_errs("clear");

        // Out-of-range read, then reset while waiting for the transmitter
        send(8'hBB, 1'b0, 1'b0);
        tx_exp.push_back(8'h00);
        send(8'h09, 1'b0, 1'b0);
        expect_err();
        n = 0;
        while (!TX_DATA_VALID && n < 50) begin
            @(negedge CLK); #1;
            n++;
        end
        check("oor_tx_fired", {31'd0, TX_DATA_VALID}, 32'd1);
        force_busy = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("oor_in_tx_wait", {31'd0, CTRL_BUSY}, 32'd1);
        check_errs("oor_rd");
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        force_busy = 1'b0;
        cnt_exp = 0;
        check("mid_rst_tx_data", {24'd0, TX_P_DATA}, 32'h00);
        check("mid_rst_tx_valid", {31'd0, TX_DATA_VALID}, 32'd0);
        check("mid_rst_cmd_err", {31'd0, CMD_ERR}, 32'd0);
        check("mid_rst_err_cnt", {24'd0, ERR_CNT}, 32'd0);
        check("mid_rst_busy", {31'd0, CTRL_BUSY}, 32'd0);
        check("mid_rst_par_en", {31'd0, CFG_PAR_EN}, 32'd1);
        check("mid_rst_par_typ", {31'd0, CFG_PAR_TYP}, 32'd0);
        check("mid_rst_prescale", {27'd0, CFG_PRESCALE}, 32'd8);
        repeat (6) @(posedge CLK);
        do_read("rd_reg0_after_rst", 8'h00, 8'h21);
        do_read("rd_reg3_after_rst", 8'h03, 8'h00);
        check("queue_empty", tx_exp.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
